// File: rtl/gcd_job_ctrl_if.sv
// Stream and engine-side signals of the GCD job controller.
// Handshakes: a beat transfers on a rising edge where valid && ready; valid never drops without a transfer.
interface gcd_job_ctrl_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         gcd_start;
    logic [N-1:0] gcd_a;
    logic [N-1:0] gcd_b;
    logic         gcd_done;
    logic [N-1:0] gcd_res;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_res;
    logic         out_err;

    // Environment side: producer, engine and consumer.
    modport master (
        output in_valid, in_a, in_b, gcd_done, gcd_res, out_ready,
        input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_res, out_err
    );

    // Controller side.
    modport slave (
        input  in_valid, in_a, in_b, gcd_done, gcd_res, out_ready,
        output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_res, out_err
    );
endinterface

// File: rtl/gcd_job_ctrl.sv
// Job controller for the subtractive GCD engine: input FIFO, start/done sequencing,
// zero-operand bypass and watchdog timeout, results returned in order on a valid/ready stream.
module gcd_job_ctrl #(
    parameter int N           = 32,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         rst,
    gcd_job_ctrl_if.slave bus,
    output logic [2:0]   dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t         state;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [TW-1:0]  timer;
    logic [2*N-1:0] mem [DEPTH];
    logic [2*N-1:0] head;
    logic [N-1:0]   head_a;
    logic [N-1:0]   head_b;
    logic           push;
    logic           pop;

    // in_ready looks only at the registered count, so a full FIFO refuses a push even while popping.
    assign bus.in_ready = (count != CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == IDLE) && (count != '0);
    assign head         = mem[rd_ptr];
    assign head_a       = head[2*N-1:N];
    assign head_b       = head[N-1:0];
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            timer         <= '0;
            bus.gcd_start <= 1'b0;
            bus.gcd_a     <= '0;
            bus.gcd_b     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_res   <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            bus.gcd_start <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bus.gcd_a <= head_a;
                        bus.gcd_b <= head_b;
                        // The subtractive engine never terminates on a zero operand; answer directly.
                        if (head_a == '0 || head_b == '0) begin
                            bus.out_res   <= head_a | head_b;
                            bus.out_err   <= 1'b0;
                            bus.out_valid <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            bus.gcd_start <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (bus.gcd_done) begin
                        state <= CAPTURE;
                    end else if (timer == TMAX) begin
                        bus.out_res   <= '0;
                        bus.out_err   <= 1'b1;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                CAPTURE: begin
                    bus.out_res   <= bus.gcd_res;
                    bus.out_err   <= 1'b0;
                    bus.out_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
